// File: rtl/wb_trace_checker.sv
// Compares the CPU register-writeback stream against a preloaded expected trace.
// Define WB_SIGNATURE_EN to add a rolling 32-bit signature output (sig) of accepted writebacks.
module wb_trace_checker #(
    parameter int DEPTH   = 32,
    parameter int IW      = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [4:0]    exp_reg,
    input  logic [DW-1:0] exp_data,
    input  logic [IW:0]   exp_len,
    input  logic          wb_en,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
`ifdef WB_SIGNATURE_EN
    output logic [31:0]   sig,
`endif
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [IW:0]   match_cnt,
    output logic [IW:0]   err_cnt,
    output logic [IW-1:0] first_err_idx,
    output logic [DW-1:0] first_err_data
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [IW:0]   DEPTH_L   = (IW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW:0]   len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW:0]   match_q, match_d;
    logic [IW:0]   err_q, err_d;
    logic [IW-1:0] fe_idx_q, fe_idx_d;
    logic [DW-1:0] fe_data_q, fe_data_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
`ifdef WB_SIGNATURE_EN
    logic [31:0]   sig_q, sig_d;
`endif

    // Expected-trace table: {reg, data} per entry, not reset.
    logic [DW+4:0] table_mem [DEPTH];
    logic [DW+4:0] rd_q;
    logic          tbl_we;
    logic          accept;
    logic          last;

    assign tbl_we = exp_we && (state_q != S_RUN);
    assign accept = wb_en && (wb_addr != 5'd0);
    assign last   = ({1'b0, idx_q} == (len_q - 1'b1));

    // The read address tracks the next index, so the entry to compare is
    // already registered when the corresponding writeback arrives.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_mem[exp_idx] <= {exp_reg, exp_data};
        end
        rd_q <= table_mem[idx_d];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        timer_d   = timer_q;
        match_d   = match_q;
        err_d     = err_q;
        fe_idx_d  = fe_idx_q;
        fe_data_d = fe_data_q;
        timeout_d = timeout_q;
`ifdef WB_SIGNATURE_EN
        sig_d     = sig_q;
`endif
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    idx_d   = idx_q + 1'b1;
                    timer_d = '0;
                    if ({wb_addr, wb_data} == rd_q) begin
                        match_d = match_q + 1'b1;
                    end else begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) begin
                            fe_idx_d  = idx_q;
                            fe_data_d = wb_data;
                        end
                    end
`ifdef WB_SIGNATURE_EN
                    sig_d = {sig_q[30:0], sig_q[31]} ^ 32'(wb_data) ^ {27'b0, wb_addr};
`endif
                    if (last) begin
                        state_d = (err_d == '0) ? S_PASS : S_FAIL;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d   = S_FAIL;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    idx_d     = '0;
                    timer_d   = '0;
                    match_d   = '0;
                    err_d     = '0;
                    fe_idx_d  = '0;
                    fe_data_d = '0;
                    timeout_d = 1'b0;
`ifdef WB_SIGNATURE_EN
                    sig_d     = '0;
`endif
                    if (exp_len == '0) begin
                        state_d = S_PASS;
                    end else begin
                        len_d   = (exp_len > DEPTH_L) ? DEPTH_L : exp_len;
                        state_d = S_RUN;
                    end
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_PASS) || (state_d == S_FAIL);
        pass_d = (state_d == S_PASS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            timer_q   <= '0;
            match_q   <= '0;
            err_q     <= '0;
            fe_idx_q  <= '0;
            fe_data_q <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
`ifdef WB_SIGNATURE_EN
            sig_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            timer_q   <= timer_d;
            match_q   <= match_d;
            err_q     <= err_d;
            fe_idx_q  <= fe_idx_d;
            fe_data_q <= fe_data_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
`ifdef WB_SIGNATURE_EN
            sig_q     <= sig_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign match_cnt      = match_q;
    assign err_cnt        = err_q;
    assign first_err_idx  = fe_idx_q;
    assign first_err_data = fe_data_q;
`ifdef WB_SIGNATURE_EN
    assign sig            = sig_q;
`endif

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: per-cycle vector table plus hand-written corner sequences.
module tb_wb_trace_checker;

    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int DW    = 32;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic [4:0]    exp_reg = '0;
    logic [DW-1:0] exp_data = '0;
    logic [IW:0]   exp_len = '0;
    logic          wb_en = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          busy, done, pass, timeout;
    logic [IW:0]   match_cnt, err_cnt;
    logic [IW-1:0] first_err_idx;
    logic [DW-1:0] first_err_data;
`ifdef WB_SIGNATURE_EN
    logic [31:0]   sig;
`endif

    wb_trace_checker #(.DEPTH(DEPTH), .IW(IW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_reg(exp_reg), .exp_data(exp_data), .exp_len(exp_len),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef WB_SIGNATURE_EN
        .sig(sig),
`endif
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .match_cnt(match_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    // {busy, done, pass, timeout, match, err, first_err_idx, first_err_data}
    typedef logic [46:0] stat_t;

    typedef struct {
        logic        start;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        stat_t       exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[16];
    logic [31:0] tbl_data [DEPTH];

    function automatic stat_t mk(input logic b, input logic d, input logic p, input logic t,
                                 input int m, input int e, input int fi, input logic [31:0] fd);
        return {b, d, p, t, 4'(m), 4'(e), 3'(fi), fd};
    endfunction

    function automatic vec_t mkv(input logic s, input logic en, input int a,
                                 input logic [31:0] d, input stat_t ex);
        vec_t v;
        v.start = s; v.wb_en = en; v.wb_addr = 5'(a); v.wb_data = d; v.exp = ex;
        return v;
    endfunction

    function automatic stat_t cur();
        return {busy, done, pass, timeout, match_cnt, err_cnt, first_err_idx, first_err_data};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end else begin
            $display("ok   %s val=%h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int r, input logic [31:0] d);
        exp_we = 1'b1; exp_idx = IW'(idx); exp_reg = 5'(r); exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic wb(input int r, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = 5'(r); wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // Start a 3-entry run and replay the loaded table exactly.
    task automatic run3(input string name);
        exp_len = 4'd3;
        start = 1'b1; tick(); start = 1'b0;
        wb(1, 32'h5); wb(2, 32'hA); wb(3, 32'hF);
        chk(name, 64'(cur()), 64'(mk(0, 1, 1, 0, 3, 0, 0, 0)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = mkv(1, 0, 0, 32'h0,    mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mkv(0, 1, 1, 32'h5,    mk(1, 0, 0, 0, 1, 0, 0, 0));
        vecs[2]  = mkv(0, 1, 2, 32'hA,    mk(1, 0, 0, 0, 2, 0, 0, 0));
        vecs[3]  = mkv(0, 1, 3, 32'hF,    mk(0, 1, 1, 0, 3, 0, 0, 0));
        vecs[4]  = mkv(1, 0, 0, 32'h0,    mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[5]  = mkv(0, 1, 1, 32'h5,    mk(1, 0, 0, 0, 1, 0, 0, 0));
        vecs[6]  = mkv(0, 1, 2, 32'hB,    mk(1, 0, 0, 0, 1, 1, 1, 32'hB));
        vecs[7]  = mkv(0, 1, 3, 32'hF,    mk(0, 1, 0, 0, 2, 1, 1, 32'hB));
        vecs[8]  = mkv(1, 0, 0, 32'h0,    mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[9]  = mkv(0, 1, 0, 32'hDEAD, mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[10] = mkv(0, 1, 1, 32'h5,    mk(1, 0, 0, 0, 1, 0, 0, 0));
        vecs[11] = mkv(0, 1, 0, 32'hDEAD, mk(1, 0, 0, 0, 1, 0, 0, 0));
        vecs[12] = mkv(0, 1, 2, 32'hA,    mk(1, 0, 0, 0, 2, 0, 0, 0));
        vecs[13] = mkv(0, 1, 0, 32'hDEAD, mk(1, 0, 0, 0, 2, 0, 0, 0));
        vecs[14] = mkv(0, 1, 3, 32'hF,    mk(0, 1, 1, 0, 3, 0, 0, 0));
        vecs[15] = mkv(0, 1, 1, 32'h5,    mk(0, 1, 1, 0, 3, 0, 0, 0));

        tbl_data[0] = 32'h5; tbl_data[1] = 32'hA; tbl_data[2] = 32'hF;
        for (int i = 3; i < DEPTH; i++) tbl_data[i] = 32'(i * 32'h11);

        // Reset state
        tick(); tick();
        chk("reset_state", 64'(cur()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;
        tick();

        load(0, 1, 32'h5); load(1, 2, 32'hA); load(2, 3, 32'hF);
        exp_len = 4'd3;

        // Pass run, fail run, r0-interleaved run
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start; wb_en = vecs[i].wb_en;
            wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            tick();
            chk($sformatf("vec%0d", i), 64'(cur()), 64'(vecs[i].exp));
        end
        start = 1'b0; wb_en = 1'b0;

        // Timeout: one match then silence
        exp_len = 4'd2;
        start = 1'b1; tick(); start = 1'b0;
        wb(1, 32'h5);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (done) break;
        end
        chk("timeout_cycles", 64'(n), 64'(TMO));
        chk("timeout_state", 64'(cur()), 64'(mk(0, 1, 0, 1, 1, 0, 0, 0)));

        // Zero-length run
        exp_len = 4'd0;
        start = 1'b1; tick(); start = 1'b0;
        chk("len_zero", 64'(cur()), 64'(mk(0, 1, 1, 0, 0, 0, 0, 0)));

        // Table writes and start are ignored while running
        exp_len = 4'd3;
        start = 1'b1; tick(); start = 1'b0;
        exp_we = 1'b1; exp_idx = '0; exp_reg = 5'd7; exp_data = 32'h99;
        wb(1, 32'h5);
        exp_we = 1'b0;
        start = 1'b1;
        wb(2, 32'hA);
        start = 1'b0;
        chk("start_in_run", 64'(cur()), 64'(mk(1, 0, 0, 0, 2, 0, 0, 0)));
        wb(3, 32'hF);
        chk("run_after_ignored", 64'(cur()), 64'(mk(0, 1, 1, 0, 3, 0, 0, 0)));
        run3("table_kept");

        // Async reset mid-run, then rerun on the retained table
        start = 1'b1; tick(); start = 1'b0;
        wb(1, 32'h5);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", 64'(cur()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        #2 rst = 1'b1;
        run3("rerun_after_reset");

        // exp_len above DEPTH clamps to DEPTH
        for (int i = 3; i < DEPTH; i++) load(i, i + 1, tbl_data[i]);
        exp_len = 4'd15;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) wb(i + 1, tbl_data[i]);
        chk("clamp_not_early", 64'(cur()), 64'(mk(1, 0, 0, 0, 7, 0, 0, 0)));
        wb(DEPTH, tbl_data[DEPTH-1]);
        chk("clamp_pass", 64'(cur()), 64'(mk(0, 1, 1, 0, 8, 0, 0, 0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
